sprite_pool: RTL and testbench
==============================

SPRITE_POOL -- requirements
Module: sprite_pool

Interface
REQ-001 SHALL have parameter N_SLOTS, default 8, number of independent moving objects.
REQ-002 SHALL have parameter OBJ_W, default 4, object width in pixels.
REQ-003 SHALL have parameter OBJ_H, default 8, object height in pixels.
REQ-004 SHALL have parameter SPEED, default 4, vertical pixels moved per clock.
REQ-005 SHALL have parameter COOLDOWN, default 8, clocks between accepted spawns.
REQ-006 SHALL have port clk_60hz  in  1  game-logic clock, all state on rising edge; one clock only.
REQ-007 SHALL have port reset  in  1  synchronous, active-high.
REQ-008 SHALL have ports px, py  in  10 each  current VGA pixel coordinate.
REQ-009 SHALL have ports spawn  in  1  spawn request (level); spawn_x, spawn_y  in  10 each  spawn position; spawn_dir  in  1  0=up, 1=down.
REQ-010 SHALL have port kill  in  N_SLOTS  per-slot destroy request (from collision logic).
REQ-011 SHALL have ports pixel  out  1  OR of slot pixels; slot_pixel  out  N_SLOTS; active  out  N_SLOTS  slot non-IDLE.
REQ-012 SHALL have ports spawn_ack  out  1  one-clock pulse on accepted spawn; full  out  1; count  out  $clog2(N_SLOTS+1)  number of non-IDLE slots.

Function
REQ-013 Each slot SHALL hold state IDLE/ACTIVE (plus EXPLODE, see REQ-026), x[9:0], y[9:0], dir.
REQ-014 spawn SHALL be rising-edge detected against a registered copy; a held spawn yields exactly one request.
REQ-015 A request with cooldown==0 and full==0 SHALL load the lowest-index IDLE slot with spawn_x/spawn_y/spawn_dir, set it ACTIVE next cycle, pulse spawn_ack, and load cooldown with COOLDOWN.
REQ-016 A request while full or cooldown!=0 SHALL be dropped: no ack, no slot change, cooldown not reloaded.
REQ-017 cooldown SHALL decrement by 1 per clock while nonzero, saturating at 0.
REQ-018 ACTIVE slot, dir=0: y SHALL retire to IDLE when y<SPEED, else y<=y-SPEED.
REQ-019 ACTIVE slot, dir=1: y SHALL retire to IDLE when y+SPEED>480-OBJ_H, else y<=y+SPEED; no wrap-around ever.
REQ-020 kill[i] on an ACTIVE slot SHALL take precedence over move/retire in the same cycle; kill on IDLE/EXPLODE slot SHALL be ignored.
REQ-021 A slot freed in cycle t SHALL NOT be allocatable before cycle t+1 (allocation uses registered state only).
REQ-022 slot_pixel[i] SHALL be combinational: active[i] && x<=px<x+OBJ_W && y<=py<y+OBJ_H; pixel = |slot_pixel.
REQ-023 full and count SHALL be combinational from registered slot states; full = (count==N_SLOTS).
REQ-024 Coordinate arithmetic SHALL use 11-bit intermediates to prevent overflow in bound checks.

Reset
REQ-025 On reset: all slots IDLE, x=y=0, dir=0, cooldown=0, spawn_ack=0, edge register=1 (spawn held through reset does not fire); pixel/slot_pixel/active=0, count=0, full=0; reset mid-flight discards all objects.

Configuration
REQ-026 With SPRITE_POOL_EXPLODE_EN defined: kill moves slot to EXPLODE for 4 clocks (position frozen, drawn as box enlarged by 2 px each side, active=1), then IDLE.
REQ-027 Without SPRITE_POOL_EXPLODE_EN: kill moves slot directly to IDLE; EXPLODE state and its counter not built.

Structure
REQ-028 Package sprite_pkg SHALL hold slot-state enum, COORD_W=10, SCREEN_W=640, SCREEN_H=480.
REQ-029 Per-slot logic SHALL be sub-module sprite_slot, generated N_SLOTS times; allocator priority encoder and cooldown stay in top.

Verification
REQ-030 Reset, spawn rise at (100,400) dir=0 -> ack 1 clk, slot0 ACTIVE, y=396 next clk; retires after y reaches <4 (y=0 case: IDLE).
REQ-031 Spawn held high 20 clks -> exactly one ack; second rise at clk 5 after ack dropped, rise at clk 8 accepted into slot1.
REQ-032 Fill 8 slots (rises ≥8 clks apart) -> full=1, count=8; 9th rise -> no ack; kill[3] -> next rise allocates slot3.
REQ-033 kill[2] same cycle as slot2 boundary retire -> slot2 IDLE, count decremented exactly once; with EXPLODE_EN, active[2] stays 1 for 4 clks.
REQ-034 px/py sweep over object at (50,50) -> pixel=1 exactly for px 50..53, py 50..57.
REQ-035 Reset asserted with 5 slots ACTIVE and cooldown 6 -> next clk count=0, cooldown=0, no ack while spawn held.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite pool: slot states, screen geometry and a
// helper that widens a coordinate to the 11-bit bound-check width.
package sprite_pkg;

  localparam int COORD_W      = 10;
  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int EXPLODE_CLKS = 4;
  localparam int EXPLODE_PAD  = 2;

  typedef enum logic [1:0] {
    SLOT_IDLE    = 2'd0,
    SLOT_ACTIVE  = 2'd1,
    SLOT_EXPLODE = 2'd2
  } slot_state_e;

  // Zero-extend a coordinate by one bit so sums and limits never wrap.
  function automatic logic [COORD_W:0] ext(input logic [COORD_W-1:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/sprite_slot.sv
// One moving object: IDLE/ACTIVE(/EXPLODE) state, position and direction,
// plus its combinational pixel hit test.
// Optional feature macro: SPRITE_POOL_EXPLODE_EN (kill shows a 4-clock
// enlarged explosion before the slot frees up).
module sprite_slot
  import sprite_pkg::*;
#(
  parameter int OBJ_W = 4,
  parameter int OBJ_H = 8,
  parameter int SPEED = 4
) (
  input  logic               clk_60hz,
  input  logic               reset,
  input  logic               load,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  input  logic               load_dir,
  input  logic               kill,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  output slot_state_e        state,
  output logic               pixel
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [COORD_W-1:0] SPEED_C  = COORD_W'(SPEED);
  localparam logic [COORD_W:0]   SPEED_X  = CW1'(SPEED);
  localparam logic [COORD_W:0]   BOTTOM_X = CW1'(SCREEN_H - OBJ_H);
  localparam logic [COORD_W:0]   W_X      = CW1'(OBJ_W);
  localparam logic [COORD_W:0]   H_X      = CW1'(OBJ_H);

  slot_state_e        state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               dir_q, dir_d;
  logic [COORD_W:0]   y_dn;
  logic [COORD_W:0]   pad;
  logic               in_x, in_y;
`ifdef SPRITE_POOL_EXPLODE_EN
  logic [1:0]         boom_q, boom_d;
`endif

  // Next-state: load when idle, otherwise kill beats move/retire.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    y_dn    = ext(y_q) + SPEED_X;
`ifdef SPRITE_POOL_EXPLODE_EN
    boom_d  = boom_q;
`endif
    case (state_q)
      SLOT_IDLE: begin
        if (load) begin
          state_d = SLOT_ACTIVE;
          x_d     = load_x;
          y_d     = load_y;
          dir_d   = load_dir;
        end
      end
      SLOT_ACTIVE: begin
        if (kill) begin
`ifdef SPRITE_POOL_EXPLODE_EN
          state_d = SLOT_EXPLODE;
          boom_d  = 2'(EXPLODE_CLKS - 1);
`else
          state_d = SLOT_IDLE;
`endif
        end else if (!dir_q) begin
          if (ext(y_q) < SPEED_X) state_d = SLOT_IDLE;
          else                    y_d     = y_q - SPEED_C;
        end else begin
          if (y_dn > BOTTOM_X) state_d = SLOT_IDLE;
          else                 y_d     = y_dn[COORD_W-1:0];
        end
      end
      SLOT_EXPLODE: begin
`ifdef SPRITE_POOL_EXPLODE_EN
        if (boom_q == 2'd0) state_d = SLOT_IDLE;
        else                boom_d  = boom_q - 2'd1;
`else
        state_d = SLOT_IDLE;
`endif
      end
      default: state_d = SLOT_IDLE;
    endcase
  end

  // Slot registers.
  always_ff @(posedge clk_60hz) begin
    if (reset) begin
      state_q <= SLOT_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= 1'b0;
`ifdef SPRITE_POOL_EXPLODE_EN
      boom_q  <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
`ifdef SPRITE_POOL_EXPLODE_EN
      boom_q  <= boom_d;
`endif
    end
  end

  // Hit test; an exploding object is drawn enlarged on every side.
  always_comb begin
    pad = '0;
`ifdef SPRITE_POOL_EXPLODE_EN
    if (state_q == SLOT_EXPLODE) pad = CW1'(EXPLODE_PAD);
`endif
    in_x  = (ext(px) + pad >= ext(x_q)) && (ext(px) < ext(x_q) + W_X + pad);
    in_y  = (ext(py) + pad >= ext(y_q)) && (ext(py) < ext(y_q) + H_X + pad);
    pixel = (state_q != SLOT_IDLE) && in_x && in_y;
  end

  assign state = state_q;

endmodule

// File: rtl/sprite_pool.sv
// Pool of N_SLOTS independent moving objects with a rising-edge spawn
// request, lowest-free-slot allocator and spawn cooldown.
// Optional feature macro: SPRITE_POOL_EXPLODE_EN (handled inside sprite_slot).
//
// Handshake: spawn is a level input; each 0->1 transition is one request.
// An accepted request produces a one-clock spawn_ack pulse in the same cycle
// the new slot first reads as active; dropped requests get no ack at all.
module sprite_pool
  import sprite_pkg::*;
#(
  parameter int N_SLOTS  = 8,
  parameter int OBJ_W    = 4,
  parameter int OBJ_H    = 8,
  parameter int SPEED    = 4,
  parameter int COOLDOWN = 8
) (
  input  logic                         clk_60hz,
  input  logic                         reset,
  input  logic [COORD_W-1:0]           px,
  input  logic [COORD_W-1:0]           py,
  input  logic                         spawn,
  input  logic [COORD_W-1:0]           spawn_x,
  input  logic [COORD_W-1:0]           spawn_y,
  input  logic                         spawn_dir,
  input  logic [N_SLOTS-1:0]           kill,
  output logic                         pixel,
  output logic [N_SLOTS-1:0]           slot_pixel,
  output logic [N_SLOTS-1:0]           active,
  output logic                         spawn_ack,
  output logic                         full,
  output logic [$clog2(N_SLOTS+1)-1:0] count
);

  localparam int CNT_W = $clog2(N_SLOTS + 1);
  localparam int CD_W  = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

  slot_state_e        slot_state [N_SLOTS];
  logic               spawn_q, spawn_d;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic               ack_q, ack_d;
  logic [N_SLOTS-1:0] load_vec;
  logic               req, accept, found;

  // Occupancy summary from registered slot states only.
  always_comb begin
    active = '0;
    count  = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      active[i] = (slot_state[i] != SLOT_IDLE);
      count     = count + CNT_W'(active[i]);
    end
    full  = (count == CNT_W'(N_SLOTS));
    pixel = |slot_pixel;
  end

  // Request edge detect, accept decision, lowest-index free slot, cooldown.
  always_comb begin
    req      = spawn && !spawn_q;
    accept   = req && (cd_q == '0) && !full;
    load_vec = '0;
    found    = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!found && !active[i]) begin
        load_vec[i] = accept;
        found       = 1'b1;
      end
    end
    spawn_d = spawn;
    ack_d   = accept;
    if (accept)          cd_d = CD_LOAD;
    else if (cd_q != '0) cd_d = cd_q - CD_W'(1);
    else                 cd_d = cd_q;
  end

  // Allocator registers; the edge register resets high so a spawn held
  // through reset never fires.
  always_ff @(posedge clk_60hz) begin
    if (reset) begin
      spawn_q <= 1'b1;
      cd_q    <= '0;
      ack_q   <= 1'b0;
    end else begin
      spawn_q <= spawn_d;
      cd_q    <= cd_d;
      ack_q   <= ack_d;
    end
  end

  assign spawn_ack = ack_q;

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    sprite_slot #(
      .OBJ_W (OBJ_W),
      .OBJ_H (OBJ_H),
      .SPEED (SPEED)
    ) u_slot (
      .clk_60hz (clk_60hz),
      .reset    (reset),
      .load     (load_vec[g]),
      .load_x   (spawn_x),
      .load_y   (spawn_y),
      .load_dir (spawn_dir),
      .kill     (kill[g]),
      .px       (px),
      .py       (py),
      .state    (slot_state[g]),
      .pixel    (slot_pixel[g])
    );
  end

endmodule

// File: tb/tb_sprite_pool.sv
// Bench for sprite_pool with default parameters.
`timescale 1ns/1ps
module tb_sprite_pool;

  localparam int N  = 8;
  localparam int CD = 8;

  logic         clk_60hz = 1'b0;
  logic         reset    = 1'b1;
  logic [9:0]   px = '0, py = '0;
  logic         spawn = 1'b0;
  logic [9:0]   spawn_x = '0, spawn_y = '0;
  logic         spawn_dir = 1'b0;
  logic [N-1:0] kill = '0;
  logic         pixel;
  logic [N-1:0] slot_pixel, active;
  logic         spawn_ack, full;
  logic [3:0]   count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = -1000;
  logic [N-1:0] exp_act = '0;
  logic [N:0]   exp_q[$];

  sprite_pool dut (
    .clk_60hz(clk_60hz), .reset(reset), .px(px), .py(py), .spawn(spawn),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dir(spawn_dir), .kill(kill),
    .pixel(pixel), .slot_pixel(slot_pixel), .active(active),
    .spawn_ack(spawn_ack), .full(full), .count(count)
  );

  // Clock and edge counter.
  always #500 clk_60hz = ~clk_60hz;
  always @(posedge clk_60hz) cyc <= cyc + 1;

  initial begin
    #50_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_60hz);
    @(negedge clk_60hz);
  endtask

  task automatic do_reset();
    reset = 1'b1; spawn = 1'b0; kill = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    exp_act  = '0;
    last_acc = -1000;
  endtask

  task automatic probe(input int x, input int y, output logic p);
    px = 10'(x); py = 10'(y);
    #1;
    p = pixel;
  endtask

  task automatic wait_cd();
    for (int k = 0; k < CD + 2; k++)
      if ((cyc + 1 - last_acc) <= CD) tick();
  endtask

  // One-clock spawn pulse; expectation from the bench occupancy/cooldown model.
  task automatic spawn_rise(input int x, input int y, input logic dir);
    logic acc; int slot; logic [N-1:0] nxt; logic [N:0] e;
    acc  = (exp_act != '1) && ((cyc + 1 - last_acc) > CD);
    nxt  = exp_act;
    slot = -1;
    if (acc) begin
      for (int i = N - 1; i >= 0; i--) if (!exp_act[i]) slot = i;
      nxt[slot] = 1'b1;
    end
    exp_q.push_back({acc, nxt});
    spawn_x = 10'(x); spawn_y = 10'(y); spawn_dir = dir; spawn = 1'b1;
    tick();
    spawn = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if ({spawn_ack, active} !== e) begin
      errors++;
      $display("FAIL spawn_rise(%0d,%0d): ack_active got %b want %b", x, y, {spawn_ack, active}, e);
    end
    if (acc) begin exp_act = nxt; last_acc = cyc; end
  endtask

  task automatic test_reset();
    logic p; int acks;
    reset = 1'b1; spawn = 1'b1;
    tick(); tick();
    probe(0, 0, p);
    checks++; if ({active, count, full, spawn_ack, slot_pixel, p} !== '0) begin
      errors++; $display("FAIL reset_state: got act=%b cnt=%0d full=%b ack=%b sp=%b pix=%b want zeros",
                         active, count, full, spawn_ack, slot_pixel, p);
    end
    reset = 1'b0; acks = 0;
    for (int k = 0; k < 3; k++) begin tick(); if (spawn_ack) acks++; end
    checks++; if (acks != 0 || active !== '0) begin
      errors++; $display("FAIL reset_held_spawn: got acks=%0d act=%b want 0 0", acks, active);
    end
    spawn = 1'b0; tick();
    exp_act = '0; last_acc = -1000;
  endtask

  task automatic test_spawn_move();
    int pxs [8] = '{100, 100, 103, 104, 100,  99, 100, 100};
    int pys [8] = '{400, 399, 407, 400, 408, 400, 396, 403};
    logic pw [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic p;
    do_reset();
    spawn_rise(100, 400, 1'b0);
    for (int i = 0; i < 8; i++) begin
      probe(pxs[i], pys[i], p);
      checks++; if (p !== pw[i]) begin
        errors++; $display("FAIL spawn_pos(%0d,%0d): got %b want %b", pxs[i], pys[i], p, pw[i]);
      end
    end
    tick();
    checks++; if (spawn_ack !== 1'b0) begin errors++; $display("FAIL ack_one_clk: got %b want 0", spawn_ack); end
    probe(100, 396, p);
    checks++; if (p !== 1'b1) begin errors++; $display("FAIL move_top: got %b want 1", p); end
    probe(100, 395, p);
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL move_above: got %b want 0", p); end
    probe(100, 404, p);
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL move_below: got %b want 0", p); end
    repeat (99) tick();
    probe(100, 0, p);
    checks++; if (active !== 8'b1 || p !== 1'b1) begin
      errors++; $display("FAIL at_y0: got act=%b pix=%b want 00000001 1", active, p);
    end
    tick();
    checks++; if (active !== '0 || count !== 4'd0) begin
      errors++; $display("FAIL retire_up: got act=%b cnt=%0d want 0 0", active, count);
    end
    exp_act = '0;
  endtask

  task automatic test_held_spawn();
    logic [N:0] e; int acks;
    do_reset();
    exp_q.push_back({1'b1, 8'b1});
    spawn_x = 10'd100; spawn_y = 10'd400; spawn_dir = 1'b0; spawn = 1'b1;
    acks = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 0) begin
        e = exp_q.pop_front();
        checks++; if ({spawn_ack, active} !== e) begin
          errors++; $display("FAIL held_first: got %b want %b", {spawn_ack, active}, e);
        end
        last_acc = cyc; exp_act = 8'b1;
      end
      if (spawn_ack) acks++;
    end
    spawn = 1'b0;
    checks++; if (acks != 1 || active !== 8'b1) begin
      errors++; $display("FAIL held_once: got acks=%0d act=%b want 1 00000001", acks, active);
    end
    do_reset();
    spawn_rise(100, 400, 1'b0);
    tick();
    checks++; if (spawn_ack !== 1'b0) begin errors++; $display("FAIL ack_dropped: got %b want 0", spawn_ack); end
    repeat (4) tick();
    spawn_rise(110, 400, 1'b0);
    tick(); tick();
    spawn_rise(120, 400, 1'b0);
    checks++; if (active !== 8'b11 || count !== 4'd2) begin
      errors++; $display("FAIL cooldown_slot1: got act=%b cnt=%0d want 00000011 2", active, count);
    end
  endtask

  task automatic test_fill_full();
    do_reset();
    for (int i = 0; i < N; i++) begin wait_cd(); spawn_rise(60 * i, 470, 1'b0); end
    checks++; if (full !== 1'b1 || count !== 4'd8) begin
      errors++; $display("FAIL full: got full=%b cnt=%0d want 1 8", full, count);
    end
    wait_cd();
    spawn_rise(500, 470, 1'b0);
    kill = 8'b0000_1000;
    tick();
    kill = '0;
`ifdef SPRITE_POOL_EXPLODE_EN
    for (int k = 0; k < 4; k++) begin
      checks++; if (active[3] !== 1'b1 || count !== 4'd8) begin
        errors++; $display("FAIL explode_hold%0d: got act3=%b cnt=%0d want 1 8", k, active[3], count);
      end
      if (k < 3) tick();
    end
    tick();
`endif
    checks++; if (active !== 8'b1111_0111 || count !== 4'd7 || full !== 1'b0) begin
      errors++; $display("FAIL kill3: got act=%b cnt=%0d full=%b want 11110111 7 0", active, count, full);
    end
    exp_act[3] = 1'b0;
    spawn_rise(510, 470, 1'b0);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL refill: got cnt=%0d want 8", count); end
    wait_cd();
    kill = 8'b0010_0000; spawn = 1'b1;
    tick();
    kill = '0; spawn = 1'b0;
    checks++; if (spawn_ack !== 1'b0) begin
      errors++; $display("FAIL alloc_registered: got ack=%b want 0", spawn_ack);
    end
`ifdef SPRITE_POOL_EXPLODE_EN
    repeat (4) tick();
`else
    tick();
`endif
    exp_act[5] = 1'b0;
    spawn_rise(520, 470, 1'b0);
    checks++; if (active !== 8'hFF) begin errors++; $display("FAIL realloc5: got %b want 11111111", active); end
  endtask

  task automatic test_kill_retire();
    logic p;
    do_reset();
    spawn_rise(300, 470, 1'b0); wait_cd();
    spawn_rise(320, 470, 1'b0); wait_cd();
    kill = 8'b0100_0000;
    tick();
    kill = '0;
    checks++; if (active !== 8'b011 || count !== 4'd2) begin
      errors++; $display("FAIL kill_idle: got act=%b cnt=%0d want 00000011 2", active, count);
    end
    wait_cd();
    spawn_rise(340, 8, 1'b0);
    tick(); tick();
    checks++; if (active !== 8'b111 || count !== 4'd3) begin
      errors++; $display("FAIL pre_retire: got act=%b cnt=%0d want 00000111 3", active, count);
    end
    kill = 8'b0000_0100;
    tick();
    kill = '0;
`ifdef SPRITE_POOL_EXPLODE_EN
    for (int k = 0; k < 4; k++) begin
      checks++; if (active[2] !== 1'b1 || count !== 4'd3) begin
        errors++; $display("FAIL kill_retire_explode%0d: got act2=%b cnt=%0d want 1 3", k, active[2], count);
      end
      if (k == 0) begin
        probe(338, 0, p);
        checks++; if (p !== 1'b1) begin errors++; $display("FAIL explode_left: got %b want 1", p); end
        probe(345, 0, p);
        checks++; if (p !== 1'b1) begin errors++; $display("FAIL explode_right: got %b want 1", p); end
        probe(346, 0, p);
        checks++; if (p !== 1'b0) begin errors++; $display("FAIL explode_edge: got %b want 0", p); end
        kill = 8'b0000_0100;
      end
      if (k < 3) tick();
      kill = '0;
    end
    tick();
`endif
    checks++; if (active !== 8'b011 || count !== 4'd2) begin
      errors++; $display("FAIL kill_retire: got act=%b cnt=%0d want 00000011 2", active, count);
    end
    tick();
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL kill_retire_once: got %0d want 2", count); end
  endtask

  task automatic test_bounds();
    int ys [7]    = '{468, 469, 472, 3, 4, 8, 0};
    logic ds [7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int life [7]  = '{2, 1, 1, 1, 2, 3, 1};
    logic p;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      wait_cd();
      spawn_rise(200, ys[i], ds[i]);
      for (int k = 1; k < life[i]; k++) begin
        tick();
        checks++; if (active !== 8'b1) begin
          errors++; $display("FAIL bound_alive y=%0d k=%0d: got %b want 00000001", ys[i], k, active);
        end
        if (i == 0) begin
          probe(200, 472, p);
          checks++; if (p !== 1'b1) begin errors++; $display("FAIL bound_472: got %b want 1", p); end
        end
      end
      tick();
      checks++; if (active !== '0) begin
        errors++; $display("FAIL bound_retire y=%0d: got %b want 0", ys[i], active);
      end
      exp_act = '0;
    end
  endtask

  task automatic test_sweep();
    logic p, want;
    do_reset();
    spawn_rise(50, 50, 1'b1);
    for (int x = 46; x < 58; x++) begin
      for (int y = 46; y < 62; y++) begin
        probe(x, y, p);
        want = (x >= 50 && x <= 53 && y >= 50 && y <= 57);
        checks++; if (p !== want || slot_pixel !== {7'b0, want}) begin
          errors++; $display("FAIL sweep(%0d,%0d): got pix=%b sp=%b want %b", x, y, p, slot_pixel, want);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    int acks;
    do_reset();
    for (int i = 0; i < 5; i++) begin wait_cd(); spawn_rise(40 * i, 470, 1'b0); end
    tick(); tick();
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL five_active: got %0d want 5", count); end
    reset = 1'b1; spawn = 1'b1;
    tick();
    checks++; if (count !== 4'd0 || active !== '0 || spawn_ack !== 1'b0 || full !== 1'b0) begin
      errors++; $display("FAIL midflight_reset: got cnt=%0d act=%b ack=%b want 0 0 0", count, active, spawn_ack);
    end
    reset = 1'b0; acks = 0;
    for (int k = 0; k < 5; k++) begin tick(); if (spawn_ack) acks++; end
    checks++; if (acks != 0) begin errors++; $display("FAIL midflight_held: got acks=%0d want 0", acks); end
    spawn = 1'b0; tick();
    exp_act = '0; last_acc = -1000;
    spawn_rise(10, 300, 1'b0);
  endtask

  initial begin
    test_reset();
    test_spawn_move();
    test_held_spawn();
    test_fill_full();
    test_kill_retire();
    test_bounds();
    test_sweep();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
